morph_filter_5x5: RTL and testbench
===================================

// Module: morph_filter_5x5
// PURPOSE
//  Binary morphology stage placed directly after the 5x5 matrix generator in the frame-difference
//  motion path. It consumes the 5x5 window stream and produces one filtered bit per pixel:
//  bypass, erosion (AND of 25 bits) or dilation (OR of 25 bits). It also accumulates a per-frame
//  foreground count and raises a motion flag for the downstream box/overlay logic.
// PARAMETERS
//  IMG_HDISP      10'd640     active pixels per line
//  IMG_VDISP      10'd480     active lines per frame
//  CNT_W          19          foreground counter width (must hold IMG_HDISP*IMG_VDISP)
// PORTS
//  clk                 in   1      pixel clock
//  rst_n               in   1      synchronous reset, active-low
//  matrix_frame_vsync  in   1      frame valid, high during frame
//  matrix_frame_href   in   1      line valid
//  matrix_frame_clken  in   1      pixel strobe
//  matrix              in   5x5    [0:4] rows of [4:0]; matrix[2][2] is the centre pixel
//  mode_sel            in   2      00 bypass, 01 erode, 10 dilate, 11 bypass
//  motion_thresh       in   CNT_W  motion threshold on foreground count
//  post_frame_vsync    out  1      vsync delayed 2 cycles
//  post_frame_href     out  1      href delayed 2 cycles
//  post_frame_clken    out  1      clken delayed 2 cycles
//  post_img_Bit        out  1      filtered pixel
//  fg_count            out  CNT_W  foreground pixels of last completed frame
//  motion_flag         out  1      fg_count >= motion_thresh, for last completed frame
//  frame_done          out  1      1-cycle pulse when fg_count/motion_flag update
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): every output is 0, mode_q=00, all counters/pipe regs are 0.
//    Reset mid-frame discards the partial frame count; the first frame end after reset reports
//    only the pixels seen since reset.
//  - Mode: mode_sel is sampled into mode_q only on the vsync rising edge (vsync=1 and previous
//    vsync=0). A mid-frame change has no effect until the next frame.
//  - Pipeline, latency 2, fixed and independent of clken:
//    S1: row_r[i] = &matrix[i] (erode), |matrix[i] (dilate), or centre bit (bypass). Sync bits
//        are registered alongside.
//    S2: post_img_Bit = &row_r / |row_r / centre. Sync outputs are S1 sync values.
//  - post_img_Bit is forced to 0 whenever the S1-stage href is 0.
//  - Stats: when post_frame_href&post_frame_clken&post_img_Bit, fg_cnt increments. It
//    saturates at 2^CNT_W-1 and does not wrap.
//  - Frame end is the post_frame_vsync falling edge, detected with a registered copy.
//    On the frame-end cycle: fg_count <= fg_cnt (+1 if a qualifying pixel occurs in that same
//    cycle), motion_flag <= (that value >= motion_thresh), frame_done=1, and fg_cnt clears to 0.
//  - motion_thresh is sampled only on the frame-end cycle. A threshold of 0 always sets
//    motion_flag.
//  - A frame with no qualifying pixels still produces frame_done with fg_count=0.
// CONFIGURATION
//  MORPH_BORDER_ZERO_EN defined:
//   - col counter: counts S1-qualified pixels (href&clken) and clears when href is low.
//   - row counter: increments on each S1 href falling edge and clears when vsync is low.
//   - post_img_Bit is forced to 0 when col<2, col>=IMG_HDISP-2, row<2 or row>=IMG_VDISP-2.
//     This applies in all modes.
//   - Border-forced zeros are excluded from fg_cnt.
//   - Latency is unchanged at 2.
//  MORPH_BORDER_ZERO_EN undefined: no counters; the border is treated like any other pixel.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clk with random inputs -> all outputs 0 on each clk.
//    Release -> outputs stay 0 until inputs are valid.
//  2 Latency/bypass: mode 00, centre bit toggles each clken -> post_img_Bit equals the centre
//    bit 2 clk later. Sync outputs are inputs delayed by exactly 2.
//  3 Erode/dilate: mode 01 with all-ones except matrix[4][0]=0 -> output 0.
//    Mode 10 with only matrix[0][4]=1 -> output 1.
//  4 Mode latch: set mode_sel 01->10 mid-frame -> erode persists to frame end.
//    The next frame uses dilate.
//  5 Stats: 640x480 frame with 1000 ones, motion_thresh=1000 -> frame_done pulse, fg_count=1000,
//    motion_flag=1. Repeat with motion_thresh=1001 -> motion_flag=0.
//  6 MORPH_BORDER_ZERO_EN: all-ones frame in bypass -> first 2 and last 2 rows/cols output 0.
//    fg_count=636*476=302736.

Source files
------------

// File: rtl/morph_filter_5x5.sv
// 5x5 binary morphology (bypass/erode/dilate) plus per-frame foreground count and motion flag.
// Fixed 2-cycle latency, no backpressure; MORPH_BORDER_ZERO_EN zeroes a 2-pixel frame border.
module morph_filter_5x5 #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480,
    parameter int         CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_frame_vsync,
    input  logic             matrix_frame_href,
    input  logic             matrix_frame_clken,
    input  logic [0:4][4:0]  matrix,
    input  logic [1:0]       mode_sel,
    input  logic [CNT_W-1:0] motion_thresh,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic             post_img_Bit,
    output logic [CNT_W-1:0] fg_count,
    output logic             motion_flag,
    output logic             frame_done
);

    logic             vsync_q;
    logic [1:0]       mode_q;
    logic [1:0]       mode1;
    logic [4:0]       row_r;
    logic             vs1, hr1, ck1;
    logic             vs_d;
    logic [CNT_W-1:0] fg_cnt;
    logic [4:0]       row_nx;
    logic             bit_nx;
    logic             border1;
    logic             qual;
    logic             frame_end;
    logic [CNT_W-1:0] fg_nx;

    // In bypass every row carries the centre bit so S2 can pick row_r[2].
    always_comb begin
        row_nx = '0;
        for (int i = 0; i < 5; i++) begin
            case (mode_q)
                2'b01:   row_nx[i] = &matrix[i];
                2'b10:   row_nx[i] = |matrix[i];
                default: row_nx[i] = matrix[2][2];
            endcase
        end
    end

    always_comb begin
        case (mode1)
            2'b01:   bit_nx = &row_r;
            2'b10:   bit_nx = |row_r;
            default: bit_nx = row_r[2];
        endcase
    end

`ifdef MORPH_BORDER_ZERO_EN
    logic [9:0] col;
    logic [9:0] row;
    logic       border_nx;

    assign border_nx = (col < 10'd2) || (col >= IMG_HDISP - 10'd2) ||
                       (row < 10'd2) || (row >= IMG_VDISP - 10'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            border1 <= 1'b0;
        end else begin
            border1 <= border_nx;
            if (!matrix_frame_href)
                col <= '0;
            else if (matrix_frame_clken)
                col <= col + 10'd1;
            if (!matrix_frame_vsync)
                row <= '0;
            else if (hr1 && !matrix_frame_href)
                row <= row + 10'd1;
        end
    end
`else
    assign border1 = 1'b0;
`endif

    assign qual      = post_frame_href & post_frame_clken & post_img_Bit;
    assign frame_end = vs_d & ~post_frame_vsync;
    // Saturating increment; the frame-end cycle also folds in its own qualifying pixel.
    assign fg_nx     = (qual && (fg_cnt != {CNT_W{1'b1}})) ? fg_cnt + CNT_W'(1) : fg_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q          <= 1'b0;
            mode_q           <= 2'b00;
            mode1            <= 2'b00;
            row_r            <= '0;
            vs1              <= 1'b0;
            hr1              <= 1'b0;
            ck1              <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
            vs_d             <= 1'b0;
            fg_cnt           <= '0;
            fg_count         <= '0;
            motion_flag      <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            vsync_q <= matrix_frame_vsync;
            if (matrix_frame_vsync && !vsync_q)
                mode_q <= mode_sel;

            row_r <= row_nx;
            mode1 <= mode_q;
            vs1   <= matrix_frame_vsync;
            hr1   <= matrix_frame_href;
            ck1   <= matrix_frame_clken;

            post_frame_vsync <= vs1;
            post_frame_href  <= hr1;
            post_frame_clken <= ck1;
            post_img_Bit     <= hr1 & ~border1 & bit_nx;

            vs_d       <= post_frame_vsync;
            frame_done <= frame_end;
            if (frame_end) begin
                fg_count    <= fg_nx;
                motion_flag <= (fg_nx >= motion_thresh);
                fg_cnt      <= '0;
            end else begin
                fg_cnt <= fg_nx;
            end
        end
    end

endmodule

// File: tb/tb_morph_filter_5x5.sv
// Directed bench for morph_filter_5x5 on a reduced 40x30 frame; border checks follow MORPH_BORDER_ZERO_EN.
module tb_morph_filter_5x5;

    localparam int HD = 40;
    localparam int VD = 30;
    typedef logic [0:4][4:0] win_t;

`ifdef MORPH_BORDER_ZERO_EN
    localparam int E_STATS = 828;   // rows 2..24 x cols 2..37
    localparam int E_ALL   = 936;   // 26 x 36 interior
`else
    localparam int E_STATS = 1000;
    localparam int E_ALL   = 1200;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync, href, clken;
    win_t        matrix;
    logic [1:0]  mode_sel;
    logic [18:0] motion_thresh;
    logic        post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
    logic [18:0] fg_count;
    logic        motion_flag, frame_done;

    int checks = 0;
    int failures = 0;

    // Reference state for the per-cycle pipe comparison
    logic [1:0] mode_f = 2'b00;
    logic       vs_prev_m = 1'b0;
    logic       hr_prev = 1'b0;
    int         col_m = 0;
    int         row_m = 0;
    logic [3:0] prev = '0;
    bit         pix_chk = 1'b0;

    morph_filter_5x5 #(.IMG_HDISP(10'd40), .IMG_VDISP(10'd30), .CNT_W(19)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .matrix_frame_vsync (vsync),
        .matrix_frame_href  (href),
        .matrix_frame_clken (clken),
        .matrix             (matrix),
        .mode_sel           (mode_sel),
        .motion_thresh      (motion_thresh),
        .post_frame_vsync   (post_frame_vsync),
        .post_frame_href    (post_frame_href),
        .post_frame_clken   (post_frame_clken),
        .post_img_Bit       (post_img_Bit),
        .fg_count           (fg_count),
        .motion_flag        (motion_flag),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic win_t pat(input int kind, input int r, input int c);
        win_t w;
        case (kind)
            0: w = ((r * HD + c) < 1000) ? '1 : '0;
            1: begin w = '1; w[4][0] = 1'b0; end
            2: begin w = '0; w[0][4] = 1'b1; end
            3: w = '1;
            default: begin w = 25'($urandom); w[2][2] = c[0]; end
        endcase
        return w;
    endfunction

    // Apply current inputs for one clock; compare outputs with the inputs of two cycles back.
    task automatic step();
        logic e;
        logic bd;
        logic [3:0] cur;
        if (vsync && !vs_prev_m) mode_f = mode_sel;
        case (mode_f)
            2'b01:   e = &matrix;
            2'b10:   e = |matrix;
            default: e = matrix[2][2];
        endcase
        bd = 1'b0;
`ifdef MORPH_BORDER_ZERO_EN
        bd = (col_m < 2) || (col_m >= HD - 2) || (row_m < 2) || (row_m >= VD - 2);
`endif
        cur = {vsync, href, clken, href & ~bd & e};
        col_m = href ? col_m + int'(clken) : 0;
        row_m = !vsync ? 0 : ((hr_prev && !href) ? row_m + 1 : row_m);
        hr_prev = href;
        vs_prev_m = vsync;
        @(posedge clk);
        #1;
        if (pix_chk)
            check("pipe", {28'd0, post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit},
                  {28'd0, prev});
        prev = cur;
    endtask

    task automatic run_frame(input int kind, input logic [1:0] m0, input logic [1:0] m1,
                             input logic [18:0] th, input bit gaps,
                             output int done_n, output int fgc, output int mf);
        mode_sel = m0;
        motion_thresh = th;
        vsync = 1'b1; href = 1'b0; clken = 1'b0; matrix = '0;
        repeat (2) step();
        for (int r = 0; r < VD; r++) begin
            for (int c = 0; c < HD; c++) begin
                if (r == VD / 2 && c == 0) mode_sel = m1;
                if (gaps && $urandom_range(0, 2) == 0) begin
                    href = 1'b1; clken = 1'b0; matrix = 25'($urandom);
                    step();
                end
                href = 1'b1; clken = 1'b1; matrix = pat(kind, r, c);
                step();
            end
            href = 1'b0; clken = 1'b0; matrix = '0;
            repeat (3) step();
        end
        vsync = 1'b0;
        done_n = 0; fgc = -1; mf = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (frame_done) begin
                done_n++;
                fgc = int'(fg_count);
                mf = int'(motion_flag);
            end
        end
    endtask

    initial begin
        int dn, fc, mf;
        rst_n = 1'b0;
        mode_sel = 2'b00;
        motion_thresh = '0;
        for (int i = 0; i < 3; i++) begin
            vsync = 1'($urandom); href = 1'($urandom); clken = 1'($urandom);
            matrix = 25'($urandom); mode_sel = 2'($urandom); motion_thresh = 19'($urandom);
            @(posedge clk);
            #1;
            check("rst_ctl", {26'd0, post_frame_vsync, post_frame_href, post_frame_clken,
                              post_img_Bit, motion_flag, frame_done}, 32'd0);
            check("rst_cnt", {13'd0, fg_count}, 32'd0);
        end
        vsync = 1'b0; href = 1'b0; clken = 1'b0; matrix = '0; mode_sel = 2'b00;
        rst_n = 1'b1;
        pix_chk = 1'b1;
        repeat (4) step();
        check("idle_cnt", {13'd0, fg_count}, 32'd0);

        // bypass with toggling centre and clken gaps
        run_frame(4, 2'b00, 2'b00, 19'd1, 1'b1, dn, fc, mf);
        check("bypass_done", dn, 1);

        // erode latched; mid-frame switch to dilate must not take effect
        run_frame(1, 2'b01, 2'b10, 19'd1, 1'b0, dn, fc, mf);
        check("erode_done", dn, 1);
        check("erode_cnt", fc, 0);
        check("erode_flag", mf, 0);

        run_frame(1, 2'b10, 2'b10, 19'(E_ALL), 1'b0, dn, fc, mf);
        check("latch_dil_cnt", fc, E_ALL);
        check("latch_dil_flag", mf, 1);

        run_frame(2, 2'b10, 2'b10, 19'd1, 1'b0, dn, fc, mf);
        check("dilate_cnt", fc, E_ALL);

        run_frame(0, 2'b00, 2'b00, 19'(E_STATS), 1'b0, dn, fc, mf);
        check("stats_done", dn, 1);
        check("stats_cnt", fc, E_STATS);
        check("stats_flag_eq", mf, 1);

        run_frame(0, 2'b11, 2'b11, 19'(E_STATS + 1), 1'b0, dn, fc, mf);
        check("stats_cnt2", fc, E_STATS);
        check("stats_flag_hi", mf, 0);

        run_frame(3, 2'b00, 2'b00, 19'd0, 1'b0, dn, fc, mf);
        check("ones_cnt", fc, E_ALL);
        check("ones_flag_th0", mf, 1);

        // empty frame still reports
        run_frame(2, 2'b00, 2'b00, 19'd1, 1'b0, dn, fc, mf);
        check("empty_done", dn, 1);
        check("empty_cnt", fc, 0);
        check("empty_flag", mf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
